toy_load_scheduler: RTL and testbench
=====================================

# toy_load_scheduler

Arbitrates multiple requesters that each want to load one byte into a bank of one-shot loader slots. Each slot accepts exactly one write per reset, the same write-once behaviour as the team's toy loader. The block sits between the requesters and the loader bank. It grants one request at a time, drives a one-cycle `load_enable` pulse to the target slot, keeps a sticky map of loaded slots, and reports duplicate or out-of-range requests. Once every slot is loaded it stops accepting requests.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `N_SLOTS`, default 8: number of loader slots (2..16).
- `DATA_W`, default 8: data byte width.
- `SLOT_W` (derived): `$clog2(N_SLOTS)`, minimum 1.

Ports. Reset is `reset`: synchronous, active-high. Clock is `clk`.
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  N_REQ  request pending, one bit per requester
- `req_slot`  in  N_REQ*SLOT_W  target slot per requester, packed with requester 0 in the LSBs
- `req_data`  in  N_REQ*DATA_W  byte per requester, packed with requester 0 in the LSBs
- `req_ready`  out  N_REQ  one-cycle consume pulse, one-hot
- `load_enable`  out  N_SLOTS  one-hot, one-cycle pulse to the target slot
- `load_data`  out  DATA_W  byte for the slot; valid while `load_enable` is nonzero
- `slot_loaded`  out  N_SLOTS  sticky map of loaded slots
- `all_loaded`  out  1  high when `slot_loaded` is all ones
- `err_dup`  out  1  one-cycle pulse: request targeted a slot that is already loaded
- `err_range`  out  1  one-cycle pulse: request had `req_slot >= N_SLOTS`
- `err_req`  out  $clog2(N_REQ)  index of the requester that caused the error; valid during an error pulse

## Operation
- The FSM has three states: IDLE, ISSUE, DONE.
- **IDLE.** If any `req_valid` bit is high, pick grant `g` and register `req_slot[g]` and `req_data[g]`. Go to ISSUE.
- **ISSUE** lasts exactly one cycle. `req_ready[g]` is 1, and exactly one of the following happens:
  - **Valid slot, not yet loaded:** `load_enable[slot]` = 1, `load_data` = the registered byte. `slot_loaded[slot]` is set at the end of the cycle.
  - **Slot already loaded:** `err_dup` = 1, `err_req` = `g`, no `load_enable`.
  - **Slot out of range:** `err_range` = 1, `err_req` = `g`, no `load_enable`.
- **Leaving ISSUE:** go to DONE if `slot_loaded` (including any bit set this cycle) is all ones; otherwise go to IDLE.
- **DONE** is absorbing until reset. `req_ready` stays 0 and `all_loaded` stays 1. Pending requests are never consumed.
- Requester rule: keep `req_valid` high with `req_slot` and `req_data` stable until `req_ready` pulses. A request whose `req_valid` drops before grant is simply not seen.
- Outside ISSUE, `load_data` is 0.

## Timing
- **Reset values:** state = IDLE, `req_ready` = 0, `load_enable` = 0, `load_data` = 0, `slot_loaded` = 0, `all_loaded` = 0, `err_*` = 0, RR pointer = 0.
- **Latency:** `req_valid` sampled high in IDLE at cycle t produces the ISSUE outputs at cycle t+1.
- **Throughput:** at most one grant every 2 cycles.
- **Simultaneous requests:** only one is granted; the losers wait.
- **Reset mid-ISSUE:** the pulse is suppressed from the next edge, and `slot_loaded` clears.
- **Ready pulse:** `req_ready` is asserted only in ISSUE, never in IDLE or DONE.
- **Slot range:** with `N_SLOTS` a power of two, `err_range` can never fire.

## Configuration
- Macro: `TOY_LOAD_SCHED_RR_EN`.
- **Defined:** round-robin arbitration. The search starts at the pointer. After each grant, pointer = (g+1) mod N_REQ, updated on error grants too.
- **Undefined:** fixed priority, lowest index wins. There is no pointer register.

## Structure
- Package `toy_load_pkg` holds:
  - state enum `sched_state_t` {IDLE, ISSUE, DONE};
  - function `slot_w(n)`.
- Sub-module `toy_rr_arbiter`: combinational one-hot grant from `req_valid` and the pointer. The RR/fixed-priority selection lives inside it, controlled by the macro. This is the only sub-module.

## Test plan
- **Single request, basic load:** reset, then req0 valid with slot 3, data 0xA5.
  - Cycle t+1: `load_enable` = 8'b0000_1000, `load_data` = 0xA5, `req_ready` = 4'b0001.
  - Cycle t+2: `slot_loaded[3]` = 1.
- **Duplicate slot:** req1 requests slot 3 again with 0x5A. Required: `err_dup` = 1, `err_req` = 1, `load_enable` = 0, `req_ready` = 4'b0010.
- **Round-robin order (RR_EN defined):** all four requesters held valid with distinct slots 0, 1, 2, 4. Grants come in order 0, 1, 2, 3, at 2-cycle spacing. With RR_EN undefined the same stimulus gives the same order; then re-raise req0 while req3 is pending and check that req0 is granted before req3.
- **Out of range:** N_SLOTS = 6, req2 requests slot 7. Required: `err_range` = 1, `err_req` = 2, no `load_enable`.
- **Fill and lock:** load all 8 slots. Required: `all_loaded` = 1 and state DONE. A further `req_valid` is held for 10 cycles and `req_ready` stays 0 throughout.
- **Reset mid-ISSUE:** assert `reset` during the ISSUE cycle. After the next edge, every output is at its reset value and the slot can be loaded again.

Source files
------------

// File: rtl/toy_load_pkg.sv
// Shared types and helpers for the toy load scheduler.
package toy_load_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } sched_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned slot_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/toy_rr_arbiter.sv
// One-hot grant selection; round-robin from ptr when TOY_LOAD_SCHED_RR_EN
// is defined, otherwise fixed priority with the lowest index winning.
module toy_rr_arbiter
  import toy_load_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = slot_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
`ifdef TOY_LOAD_SCHED_RR_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef TOY_LOAD_SCHED_RR_EN
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ))
        sum = sum - (IDX_W+1)'(N_REQ);
`else
      sum = (IDX_W+1)'(k);
`endif
      idx = sum[IDX_W-1:0];
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/toy_load_scheduler.sv
// Grants one byte-load request at a time into write-once loader slots.
// Arbitration is round-robin when TOY_LOAD_SCHED_RR_EN is defined.
module toy_load_scheduler
  import toy_load_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned N_SLOTS = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned SLOT_W  = slot_w(N_SLOTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*SLOT_W-1:0]   req_slot,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_SLOTS-1:0]        load_enable,
  output logic [DATA_W-1:0]         load_data,
  output logic [N_SLOTS-1:0]        slot_loaded,
  output logic                      all_loaded,
  output logic                      err_dup,
  output logic                      err_range,
  output logic [$clog2(N_REQ)-1:0]  err_req
);

  localparam int unsigned IDX_W = $clog2(N_REQ);

  sched_state_t      state;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic [SLOT_W-1:0] g_slot;
  logic [DATA_W-1:0] g_data;
  logic              g_range;
  logic [N_SLOTS-1:0] loaded_next;

`ifdef TOY_LOAD_SCHED_RR_EN
  logic [IDX_W-1:0]  ptr;
`endif

  toy_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req_valid (req_valid),
`ifdef TOY_LOAD_SCHED_RR_EN
    .ptr       (ptr),
`endif
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign g_slot      = req_slot[grant_idx*SLOT_W +: SLOT_W];
  assign g_data      = req_data[grant_idx*DATA_W +: DATA_W];
  assign g_range     = {1'b0, g_slot} >= (SLOT_W+1)'(N_SLOTS);
  assign loaded_next = slot_loaded | load_enable;
  assign all_loaded  = &slot_loaded;

  // The ISSUE outcome is decided at the IDLE->ISSUE edge so every ISSUE output is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req_ready   <= '0;
      load_enable <= '0;
      load_data   <= '0;
      slot_loaded <= '0;
      err_dup     <= 1'b0;
      err_range   <= 1'b0;
      err_req     <= '0;
`ifdef TOY_LOAD_SCHED_RR_EN
      ptr         <= '0;
`endif
    end else begin
      req_ready   <= '0;
      load_enable <= '0;
      load_data   <= '0;
      err_dup     <= 1'b0;
      err_range   <= 1'b0;
      err_req     <= '0;
      case (state)
        IDLE: begin
          if (|req_valid) begin
            state     <= ISSUE;
            req_ready <= grant;
            if (g_range) begin
              err_range <= 1'b1;
              err_req   <= grant_idx;
            end else if (slot_loaded[g_slot]) begin
              err_dup <= 1'b1;
              err_req <= grant_idx;
            end else begin
              load_enable <= N_SLOTS'(1) << g_slot;
              load_data   <= g_data;
            end
`ifdef TOY_LOAD_SCHED_RR_EN
            ptr <= (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
`endif
          end
        end
        ISSUE: begin
          slot_loaded <= loaded_next;
          state       <= (&loaded_next) ? DONE : IDLE;
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_toy_load_scheduler.sv
// Directed bench for toy_load_scheduler (8-slot main instance, 6-slot range instance).
module tb_toy_load_scheduler;
  import toy_load_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [11:0] req_slot = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  load_enable;
  logic [7:0]  load_data;
  logic [7:0]  slot_loaded;
  logic        all_loaded, err_dup, err_range;
  logic [1:0]  err_req;

  logic [3:0]  r6_valid = '0;
  logic [11:0] r6_slot = '0;
  logic [31:0] r6_data = '0;
  logic [3:0]  r6_ready;
  logic [5:0]  r6_load_enable;
  logic [7:0]  r6_load_data;
  logic [5:0]  r6_slot_loaded;
  logic        r6_all_loaded, r6_err_dup, r6_err_range;
  logic [1:0]  r6_err_req;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  toy_load_scheduler #(.N_REQ(4), .N_SLOTS(8), .DATA_W(8)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_slot(req_slot),
    .req_data(req_data), .req_ready(req_ready), .load_enable(load_enable),
    .load_data(load_data), .slot_loaded(slot_loaded), .all_loaded(all_loaded),
    .err_dup(err_dup), .err_range(err_range), .err_req(err_req)
  );

  toy_load_scheduler #(.N_REQ(4), .N_SLOTS(6), .DATA_W(8)) u_r6 (
    .clk(clk), .reset(reset), .req_valid(r6_valid), .req_slot(r6_slot),
    .req_data(r6_data), .req_ready(r6_ready), .load_enable(r6_load_enable),
    .load_data(r6_load_data), .slot_loaded(r6_slot_loaded), .all_loaded(r6_all_loaded),
    .err_dup(r6_err_dup), .err_range(r6_err_range), .err_req(r6_err_req)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [2:0] slot, input logic [7:0] data);
    req_valid[i]         = v;
    req_slot[i*3 +: 3]   = slot;
    req_data[i*8 +: 8]   = data;
  endtask

  task automatic expect_grant(input string tag, input int k, input int slot, input logic [7:0] data);
    tick();
    check({tag, "_ready"}, 32'(req_ready), 32'(1) << k);
    check({tag, "_en"}, 32'(load_enable), 32'(1) << slot);
    check({tag, "_data"}, 32'(load_data), 32'(data));
    check({tag, "_dup"}, 32'(err_dup), 32'd0);
    req_valid[k] = 1'b0;
    tick();
    check({tag, "_ready_off"}, 32'(req_ready), 32'd0);
    check({tag, "_en_off"}, 32'(load_enable), 32'd0);
    check({tag, "_data_off"}, 32'(load_data), 32'd0);
    check({tag, "_loaded"}, 32'(slot_loaded[slot]), 32'd1);
  endtask

  initial begin
    // reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_en", 32'(load_enable), 32'd0);
    check("rst_data", 32'(load_data), 32'd0);
    check("rst_loaded", 32'(slot_loaded), 32'd0);
    check("rst_all", 32'(all_loaded), 32'd0);
    check("rst_errs", 32'({err_dup, err_range, err_req}), 32'd0);

    // single request, basic load
    set_req(0, 1'b1, 3'd3, 8'hA5);
    expect_grant("basic", 0, 3, 8'hA5);
    check("basic_map", 32'(slot_loaded), 32'h08);

    // duplicate slot
    set_req(1, 1'b1, 3'd3, 8'h5A);
    tick();
    check("dup_err", 32'(err_dup), 32'd1);
    check("dup_req", 32'(err_req), 32'd1);
    check("dup_en", 32'(load_enable), 32'd0);
    check("dup_ready", 32'(req_ready), 32'h2);
    req_valid[1] = 1'b0;
    tick();
    check("dup_err_off", 32'(err_dup), 32'd0);
    check("dup_map", 32'(slot_loaded), 32'h08);

    // out of range on the 6-slot instance
    r6_valid[2] = 1'b1;
    r6_slot[8:6] = 3'd7;
    r6_data[23:16] = 8'h77;
    tick();
    check("rng_err", 32'(r6_err_range), 32'd1);
    check("rng_req", 32'(r6_err_req), 32'd2);
    check("rng_en", 32'(r6_load_enable), 32'd0);
    check("rng_ready", 32'(r6_ready), 32'h4);
    check("rng_dup", 32'(r6_err_dup), 32'd0);
    r6_valid = '0;
    tick();
    check("rng_err_off", 32'(r6_err_range), 32'd0);
    check("rng_map", 32'(r6_slot_loaded), 32'd0);

    // ordering with all four requesters pending
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, 3'd0, 8'h10);
    set_req(1, 1'b1, 3'd1, 8'h11);
    set_req(2, 1'b1, 3'd2, 8'h12);
    set_req(3, 1'b1, 3'd4, 8'h13);
    expect_grant("ord0", 0, 0, 8'h10);
    expect_grant("ord1", 1, 1, 8'h11);
    expect_grant("ord2", 2, 2, 8'h12);
    expect_grant("ord3", 3, 4, 8'h13);
    check("ord_map", 32'(slot_loaded), 32'h17);

    // re-raise req0 while req3 waits
    set_req(2, 1'b1, 3'd5, 8'h25);
    set_req(3, 1'b1, 3'd6, 8'h36);
    expect_grant("pend2", 2, 5, 8'h25);
    set_req(0, 1'b1, 3'd7, 8'h07);
`ifdef TOY_LOAD_SCHED_RR_EN
    expect_grant("rr3", 3, 6, 8'h36);
    expect_grant("rr0", 0, 7, 8'h07);
`else
    expect_grant("fp0", 0, 7, 8'h07);
    expect_grant("fp3", 3, 6, 8'h36);
`endif
    check("pend_map", 32'(slot_loaded), 32'hF7);
    check("pend_all", 32'(all_loaded), 32'd0);

    // fill and lock
    set_req(1, 1'b1, 3'd3, 8'h33);
    expect_grant("fill", 1, 3, 8'h33);
    check("fill_map", 32'(slot_loaded), 32'hFF);
    check("fill_all", 32'(all_loaded), 32'd1);
    check("fill_state", 32'(u_dut.state), 32'(DONE));
    set_req(2, 1'b1, 3'd0, 8'h99);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("lock_ready", 32'(req_ready), 32'd0);
      check("lock_en", 32'(load_enable), 32'd0);
    end
    check("lock_all", 32'(all_loaded), 32'd1);
    req_valid = '0;

    // reset during ISSUE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_pre_map", 32'(slot_loaded), 32'd0);
    set_req(0, 1'b1, 3'd2, 8'h42);
    tick();
    check("mid_en", 32'(load_enable), 32'h04);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_ready", 32'(req_ready), 32'd0);
    check("mid_en_off", 32'(load_enable), 32'd0);
    check("mid_data", 32'(load_data), 32'd0);
    check("mid_map", 32'(slot_loaded), 32'd0);
    check("mid_all", 32'(all_loaded), 32'd0);
    check("mid_errs", 32'({err_dup, err_range, err_req}), 32'd0);
    expect_grant("reload", 0, 2, 8'h42);
    check("reload_map", 32'(slot_loaded), 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
